// File: rtl/sisc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : sisc_fetch_unit_if
// Brief    : Control-strobe and instruction-memory bundle for the SISC fetch
//            stage. The slave modport is the fetch unit; the master modport is
//            the combined control FSM / instruction memory side.
// Revision : 1.0  initial release
// ============================================================================
interface sisc_fetch_unit_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 32
);
   // control FSM strobes
   logic               pc_rst;
   logic               pc_write;
   logic               pc_sel;
   logic               br_sel;
   logic               ir_load;
   // instruction memory handshake
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   // fetch results / status
   logic [INSTR_W-1:0] ir;
   logic [3:0]         opcode;
   logic [3:0]         mm;
   logic [ADDR_W-1:0]  pc;
   logic               fetch_busy;
   logic               ir_valid;
   logic               fetch_err;

   modport master (
      output pc_rst, pc_write, pc_sel, br_sel, ir_load,
      output imem_ack, imem_rdata,
      input  imem_req, imem_addr,
      input  ir, opcode, mm, pc, fetch_busy, ir_valid, fetch_err
   );

   modport slave (
      input  pc_rst, pc_write, pc_sel, br_sel, ir_load,
      input  imem_ack, imem_rdata,
      output imem_req, imem_addr,
      output ir, opcode, mm, pc, fetch_busy, ir_valid, fetch_err
   );
endinterface
`default_nettype wire

// File: rtl/sisc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : sisc_fetch_unit
// Brief    : SISC instruction fetch stage. Holds PC and IR, computes the next
//            PC (sequential / relative / absolute) and runs a req/ack fetch
//            with a wait-state timeout that loads a NOOP and flags an error.
// Revision : 1.0  initial release
// ============================================================================
module sisc_fetch_unit #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 15
) (
   input  wire logic        clk,
   input  wire logic        rst,
   sisc_fetch_unit_if.slave bus
);

   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_addr;
   logic [INSTR_W-1:0] r_ir;
   logic               r_ir_valid;
   logic               r_err;

   logic               w_start;
   logic               w_done_ack;
   logic               w_done_to;
   logic [15:0]        w_imm;
   logic [ADDR_W-1:0]  w_imm_sext;
   logic [ADDR_W-1:0]  w_imm_zext;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic [ADDR_W-1:0]  w_target;
   logic [ADDR_W-1:0]  w_pc_next;

   // Branch immediate comes from the currently held instruction.
   assign w_imm = r_ir[15:0];

   generate
      if (ADDR_W > 16) begin : g_imm_wide
         assign w_imm_sext = {{(ADDR_W-16){w_imm[15]}}, w_imm};
         assign w_imm_zext = {{(ADDR_W-16){1'b0}}, w_imm};
      end else begin : g_imm_narrow
         assign w_imm_sext = w_imm[ADDR_W-1:0];
         assign w_imm_zext = w_imm[ADDR_W-1:0];
      end
   endgenerate

   // All PC arithmetic wraps modulo 2^ADDR_W by construction.
   assign w_pc_inc  = r_pc + 1'b1;
   assign w_target  = bus.br_sel ? w_imm_zext : (w_pc_inc + w_imm_sext);
   assign w_pc_next = bus.pc_sel ? w_target : w_pc_inc;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and fetch strobes; ir_load in WAIT and ack in IDLE are ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done_ack  = 1'b0;
      w_done_to   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.ir_load) begin
               w_start     = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.imem_ack) begin
               w_done_ack  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == c_CNT_LAST) begin
               w_done_to   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Fetch datapath: latch address at request start, count wait states, load IR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_cnt      <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_ir_valid <= w_done_ack | w_done_to;
         if (w_start) begin
            r_addr <= r_pc;
            r_cnt  <= '0;
         end else if (r_state == ST_WAIT) begin
            r_cnt  <= r_cnt + 1'b1;
         end
         if (w_done_ack)     r_ir <= bus.imem_rdata;
         else if (w_done_to) r_ir <= '0;
      end
   end

   // Program counter: pc_rst has priority over pc_write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_pc <= '0;
      else if (bus.pc_rst)   r_pc <= '0;
      else if (bus.pc_write) r_pc <= w_pc_next;
   end

   // Sticky timeout flag, cleared only by reset or pc_rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_err <= 1'b0;
      else if (bus.pc_rst) r_err <= 1'b0;
      else if (w_done_to)  r_err <= 1'b1;
   end

   // Request and busy follow the WAIT state so an async reset drops them at once.
   assign bus.imem_req   = (r_state == ST_WAIT);
   assign bus.fetch_busy = (r_state == ST_WAIT);
   assign bus.imem_addr  = r_addr;
   assign bus.ir         = r_ir;
   assign bus.opcode     = r_ir[31:28];
   assign bus.mm         = r_ir[27:24];
   assign bus.pc         = r_pc;
   assign bus.ir_valid   = r_ir_valid;
   assign bus.fetch_err  = r_err;

endmodule
`default_nettype wire
